// File: rtl/fp_cvt_widen_pipe_if.sv
// Valid/ready handshake bundle for the precision-widening converter.
// The slave modport is the converter's view; the master modport is the producer/consumer side.
interface fp_cvt_widen_pipe_if #(
    parameter int SRC_EXP = 11,
    parameter int SRC_SIG = 52,
    parameter int DST_EXP = 15,
    parameter int DST_SIG = 112
);
    logic                         i_valid;
    logic                         i_ready;
    logic [SRC_EXP+SRC_SIG:0]     i;
    logic                         o_valid;
    logic                         o_ready;
    logic [DST_EXP+DST_SIG:0]     o;
    logic [4:0]                   o_class;
    logic                         o_invalid;

    modport slave (
        input  i_valid, i, o_ready,
        output i_ready, o_valid, o, o_class, o_invalid
    );

    modport master (
        output i_valid, i, o_ready,
        input  i_ready, o_valid, o, o_class, o_invalid
    );
endinterface

// File: rtl/fp_cvt_widen_pipe.sv
// Three-stage IEEE-754 widening converter (unpack/classify, leading-zero count, pack).
// Define FPCVT_NAN_QUIET_EN to quiet sNaN inputs and raise o_invalid for them.
module fp_cvt_widen_pipe #(
    parameter int SRC_EXP = 11,
    parameter int SRC_SIG = 52,
    parameter int DST_EXP = 15,
    parameter int DST_SIG = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_cvt_widen_pipe_if.slave    bus
);

    localparam int LZW         = $clog2(SRC_SIG + 1);
    localparam int BIAS_S      = 2**(SRC_EXP-1) - 1;
    localparam int BIAS_D      = 2**(DST_EXP-1) - 1;
    localparam int BIAS_DIFF_I = BIAS_D - BIAS_S;
    localparam logic [DST_EXP-1:0] BIAS_DIFF = BIAS_DIFF_I[DST_EXP-1:0];

    if (DST_EXP <= SRC_EXP) begin : g_bad_exp_width
        $error("fp_cvt_widen_pipe: DST_EXP must exceed SRC_EXP");
    end
    if ((2**(DST_EXP-1) - 2**(SRC_EXP-1)) <= SRC_SIG + 1) begin : g_bad_exp_range
        $error("fp_cvt_widen_pipe: DST_EXP range cannot hold normalised source subnormals");
    end
    if (DST_SIG < SRC_SIG) begin : g_bad_sig_width
        $error("fp_cvt_widen_pipe: DST_SIG must be at least SRC_SIG");
    end

    typedef struct packed {
        logic snan;
        logic qnan;
        logic inf;
        logic sub;
        logic zero;
    } fp_class_t;

    // Every stage advances together; a full output register with no taker freezes the pipe.
    logic adv;
    assign adv         = !o_valid_q || bus.o_ready;
    assign bus.i_ready = adv;

    // ---------------- stage 1: unpack / classify ----------------
    logic               s1_valid_d, s1_valid_q;
    logic               s1_sign_d,  s1_sign_q;
    logic [SRC_EXP-1:0] s1_exp_d,   s1_exp_q;
    logic [SRC_SIG-1:0] s1_frac_d,  s1_frac_q;
    fp_class_t          s1_class_d, s1_class_q;

    logic [SRC_EXP-1:0] in_exp;
    logic [SRC_SIG-1:0] in_frac;
    logic               in_exp_ones, in_exp_zero, in_frac_zero;

    assign in_exp       = bus.i[SRC_EXP+SRC_SIG-1 -: SRC_EXP];
    assign in_frac      = bus.i[SRC_SIG-1:0];
    assign in_exp_ones  = &in_exp;
    assign in_exp_zero  = ~|in_exp;
    assign in_frac_zero = ~|in_frac;

    // NOTE: every always_comb output gets a default first (here: hold) so no latch is inferred.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        s1_class_d = s1_class_q;
        if (adv) begin
            s1_valid_d      = bus.i_valid;
            s1_sign_d       = bus.i[SRC_EXP+SRC_SIG];
            s1_exp_d        = in_exp;
            s1_frac_d       = in_frac;
            s1_class_d      = '0;
            s1_class_d.zero = in_exp_zero && in_frac_zero;
            s1_class_d.sub  = in_exp_zero && !in_frac_zero;
            s1_class_d.inf  = in_exp_ones && in_frac_zero;
            s1_class_d.qnan = in_exp_ones && !in_frac_zero && in_frac[SRC_SIG-1];
            s1_class_d.snan = in_exp_ones && !in_frac_zero && !in_frac[SRC_SIG-1];
        end
    end

    // ---------------- stage 2: leading-zero count ----------------
    logic               s2_valid_d, s2_valid_q;
    logic               s2_sign_d,  s2_sign_q;
    logic [SRC_EXP-1:0] s2_exp_d,   s2_exp_q;
    logic [SRC_SIG-1:0] s2_frac_d,  s2_frac_q;
    fp_class_t          s2_class_d, s2_class_q;
    logic [LZW-1:0]     s2_lz_d,    s2_lz_q;

    logic [LZW-1:0]     lz_cnt;
    logic               lz_found;

    always_comb begin
        lz_cnt   = '0;
        lz_found = 1'b0;
        for (int k = SRC_SIG-1; k >= 0; k--) begin
            if (!lz_found && s1_frac_q[k]) begin
                lz_cnt   = LZW'(SRC_SIG-1-k);
                lz_found = 1'b1;
            end
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_frac_d  = s2_frac_q;
        s2_class_d = s2_class_q;
        s2_lz_d    = s2_lz_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_exp_d   = s1_exp_q;
            s2_frac_d  = s1_frac_q;
            s2_class_d = s1_class_q;
            s2_lz_d    = lz_cnt;
        end
    end

    // ---------------- stage 3: pack ----------------
    logic                     o_valid_d, o_valid_q;
    logic [DST_EXP+DST_SIG:0] o_d,       o_q;
    fp_class_t                o_class_d, o_class_q;

    logic [SRC_SIG-1:0] frac_sh;
    logic [SRC_SIG-1:0] frac_src;
    logic [DST_EXP-1:0] exp_pk;
    logic [DST_SIG-1:0] frac_pk;

    // Shifting by lz puts the leading one at the MSB; one more shift drops it as the hidden bit.
    assign frac_sh = s2_frac_q << s2_lz_q;

    always_comb begin
        exp_pk   = DST_EXP'(s2_exp_q) + BIAS_DIFF;
        frac_src = s2_frac_q;
        if (s2_class_q.zero) begin
            exp_pk   = '0;
            frac_src = '0;
        end else if (s2_class_q.sub) begin
            exp_pk   = BIAS_DIFF - DST_EXP'(s2_lz_q);
            frac_src = {frac_sh[SRC_SIG-2:0], 1'b0};
        end else if (s2_class_q.inf || s2_class_q.qnan || s2_class_q.snan) begin
            exp_pk = '1;
`ifdef FPCVT_NAN_QUIET_EN
            if (s2_class_q.snan) begin
                frac_src[SRC_SIG-1] = 1'b1;
            end
`endif
        end
        frac_pk                        = '0;
        frac_pk[DST_SIG-1 -: SRC_SIG] = frac_src;
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_d       = o_q;
        o_class_d = o_class_q;
        if (adv) begin
            o_valid_d = s2_valid_q;
            o_d       = {s2_sign_q, exp_pk, frac_pk};
            o_class_d = s2_class_q;
        end
    end

`ifdef FPCVT_NAN_QUIET_EN
    logic o_invalid_d, o_invalid_q;

    always_comb begin
        o_invalid_d = o_invalid_q;
        if (adv) begin
            o_invalid_d = s2_class_q.snan;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_invalid_q <= 1'b0;
        end else begin
            o_invalid_q <= o_invalid_d;
        end
    end

    assign bus.o_invalid = o_invalid_q;
`else
    assign bus.o_invalid = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_frac_q  <= '0;
            s1_class_q <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
            s2_class_q <= '0;
            s2_lz_q    <= '0;
            o_valid_q  <= 1'b0;
            o_q        <= '0;
            o_class_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_frac_q  <= s1_frac_d;
            s1_class_q <= s1_class_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;
            s2_frac_q  <= s2_frac_d;
            s2_class_q <= s2_class_d;
            s2_lz_q    <= s2_lz_d;
            o_valid_q  <= o_valid_d;
            o_q        <= o_d;
            o_class_q  <= o_class_d;
        end
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o       = o_q;
    assign bus.o_class = o_class_q;

endmodule

// File: tb/tb_fp_cvt_widen_pipe.sv
// Directed bench for fp_cvt_widen_pipe at default (double -> quad) parameters.
// Expected quad words are hand-derived; class bits are {snan,qnan,inf,subnormal_in,zero}.
module tb_fp_cvt_widen_pipe;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_ZERO = 5'b00001;
    localparam logic [4:0] C_SUB  = 5'b00010;
    localparam logic [4:0] C_INF  = 5'b00100;
    localparam logic [4:0] C_QNAN = 5'b01000;
    localparam logic [4:0] C_SNAN = 5'b10000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp_cvt_widen_pipe_if bus_if ();

    fp_cvt_widen_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Sends one word with o_ready high and checks latency, value, class and invalid flag.
    task automatic run_one(input string tag, input logic [63:0] din, input logic [127:0] exp_o,
                           input logic [4:0] exp_cls, input logic exp_inv);
        int lat;
        @(negedge clk);
        bus_if.o_ready = 1'b1;
        bus_if.i_valid = 1'b1;
        bus_if.i       = din;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus_if.i_valid = 1'b0;
        while (!bus_if.o_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 128'(lat), 128'd3);
        check({tag, "_o"},   bus_if.o, exp_o);
        check({tag, "_cls"}, 128'(bus_if.o_class), 128'(exp_cls));
        check({tag, "_inv"}, 128'(bus_if.o_invalid), 128'(exp_inv));
    endtask

    logic [63:0]  bp_in  [6];
    logic [127:0] bp_exp [6];

    initial begin
        logic [127:0] held;
        logic         stalled_prev;
        logic         seen_valid;
        int           in_idx;
        int           out_idx;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus_if.i_valid = 1'b0;
        bus_if.i       = '0;
        bus_if.o_ready = 1'b1;

        bp_in[0] = 64'h3FF0000000000000; bp_exp[0] = 128'h3FFF0000_00000000_00000000_00000000;
        bp_in[1] = 64'hC004000000000000; bp_exp[1] = 128'hC0004000_00000000_00000000_00000000;
        bp_in[2] = 64'h0000000000000001; bp_exp[2] = 128'h3BCD0000_00000000_00000000_00000000;
        bp_in[3] = 64'h8000000000000000; bp_exp[3] = 128'h80000000_00000000_00000000_00000000;
        bp_in[4] = 64'h7FF0000000000000; bp_exp[4] = 128'h7FFF0000_00000000_00000000_00000000;
        bp_in[5] = 64'hFFF8000000000005; bp_exp[5] = 128'hFFFF8000_00000000_50000000_00000000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ovalid", 128'(bus_if.o_valid), 128'd0);
        check("rst_o",      bus_if.o, 128'd0);
        check("rst_cls",    128'(bus_if.o_class), 128'd0);
        check("rst_inv",    128'(bus_if.o_invalid), 128'd0);
        rst = 1'b0;

        run_one("one",     64'h3FF0000000000000, 128'h3FFF0000_00000000_00000000_00000000, C_NONE, 1'b0);
        run_one("neg2p5",  64'hC004000000000000, 128'hC0004000_00000000_00000000_00000000, C_NONE, 1'b0);
        run_one("maxnorm", 64'h7FEFFFFFFFFFFFFF, 128'h43FEFFFF_FFFFFFFF_F0000000_00000000, C_NONE, 1'b0);
        run_one("minsub",  64'h0000000000000001, 128'h3BCD0000_00000000_00000000_00000000, C_SUB,  1'b0);
        run_one("sub_b51", 64'h0008000000000000, 128'h3C000000_00000000_00000000_00000000, C_SUB,  1'b0);
        run_one("sub_b50", 64'h0004000000000000, 128'h3BFF0000_00000000_00000000_00000000, C_SUB,  1'b0);
        run_one("maxsub",  64'h000FFFFFFFFFFFFF, 128'h3C00FFFF_FFFFFFFF_E0000000_00000000, C_SUB,  1'b0);
        run_one("negzero", 64'h8000000000000000, 128'h80000000_00000000_00000000_00000000, C_ZERO, 1'b0);
        run_one("inf",     64'h7FF0000000000000, 128'h7FFF0000_00000000_00000000_00000000, C_INF,  1'b0);
        run_one("qnan",    64'hFFF8000000000005, 128'hFFFF8000_00000000_50000000_00000000, C_QNAN, 1'b0);
`ifdef FPCVT_NAN_QUIET_EN
        run_one("snan",    64'h7FF0000000000001, 128'h7FFF8000_00000000_10000000_00000000, C_SNAN, 1'b1);
`else
        run_one("snan",    64'h7FF0000000000001, 128'h7FFF0000_00000000_10000000_00000000, C_SNAN, 1'b0);
`endif

        // Back-to-back stream with o_ready low for four cycles mid-stream.
        in_idx       = 0;
        out_idx      = 0;
        stalled_prev = 1'b0;
        held         = '0;
        for (int c = 0; c < 60 && out_idx < 6; c++) begin
            @(negedge clk);
            bus_if.o_ready = !(c >= 4 && c < 8);
            bus_if.i_valid = (in_idx < 6);
            bus_if.i       = (in_idx < 6) ? bp_in[in_idx] : 64'd0;
            #1;
            if (stalled_prev && bus_if.o_valid) begin
                check("bp_hold", bus_if.o, held);
            end
            if (bus_if.o_valid && !bus_if.o_ready) begin
                check("bp_irdy", 128'(bus_if.i_ready), 128'd0);
                held         = bus_if.o;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (bus_if.o_valid && bus_if.o_ready) begin
                check($sformatf("bp_out%0d", out_idx), bus_if.o, bp_exp[out_idx]);
                out_idx++;
            end
            if (bus_if.i_valid && bus_if.i_ready) begin
                in_idx++;
            end
        end
        check("bp_count", 128'(out_idx), 128'd6);
        @(negedge clk);
        bus_if.i_valid = 1'b0;
        bus_if.o_ready = 1'b1;
        seen_valid     = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus_if.o_valid) seen_valid = 1'b1;
        end
        check("bp_nodup", 128'(seen_valid), 128'd0);

        // Reset with three words in flight, output stalled.
        @(negedge clk);
        bus_if.o_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_if.i_valid = 1'b1;
            bus_if.i       = bp_in[k];
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.i_valid = 1'b0;
        check("rst_pre_valid", 128'(bus_if.o_valid), 128'd1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 128'(bus_if.o_valid), 128'd0);
        check("rst_async_o",     bus_if.o, 128'd0);
        check("rst_async_cls",   128'(bus_if.o_class), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst            = 1'b0;
        bus_if.o_ready = 1'b1;
        seen_valid     = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.o_valid) seen_valid = 1'b1;
        end
        check("rst_no_stale", 128'(seen_valid), 128'd0);
        run_one("post_rst", 64'h3FF0000000000000, 128'h3FFF0000_00000000_00000000_00000000, C_NONE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
